// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared pc_src encodings and sequencer state type
package core_pkg;
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_TARGET = 2'd1;
  localparam logic [1:0] PC_SRC_ALU    = 2'd2;
  localparam logic [1:0] PC_SRC_PREV   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED,
    ST_ERROR
  } seq_state_e;
endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - loadable down-counter, expire asserted while the count is zero
module fetch_timer #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);
endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - fetch/execute sequencer driving pc_src and the PC load enable
module pc_seq_ctrl
  import core_pkg::*;
#(
  parameter int RESET_WAIT    = 1,
  parameter int FETCH_TIMEOUT = 8,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  input  logic             jalr,
  input  logic             stall,
  input  logic             halt,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             instr_valid,
  output logic             fetch_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam int TMAX = (FETCH_TIMEOUT > RESET_WAIT) ? FETCH_TIMEOUT : RESET_WAIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] IDLE_LOAD  = TW'(RESET_WAIT - 1);
  localparam logic [TW-1:0] FETCH_LOAD = TW'(FETCH_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic             imem_req_q, imem_req_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_timeout_q, fetch_timeout_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             idle_expire, fetch_expire, fetch_load;

  // IDLE wait: preset out of reset, so it never needs a load.
  fetch_timer #(.W(TW), .RST_VAL(IDLE_LOAD)) u_idle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (IDLE_LOAD),
    .dec      (state_q == ST_IDLE),
    .expire   (idle_expire)
  );

  assign fetch_load = (state_d == ST_FETCH) && (state_q != ST_FETCH);

  fetch_timer #(.W(TW), .RST_VAL(FETCH_LOAD)) u_fetch_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (fetch_load),
    .load_val (FETCH_LOAD),
    .dec      (state_q == ST_FETCH),
    .expire   (fetch_expire)
  );

  always_comb begin
    pc_src = PC_SRC_PREV;
    pc_en  = 1'b0;
    if ((state_q == ST_EXEC) && !halt && !stall) begin
      pc_en = 1'b1;
      if (jalr) begin
        pc_src = PC_SRC_ALU;
      end else if (jump || (branch && zero)) begin
        pc_src = PC_SRC_TARGET;
      end else begin
        pc_src = PC_SRC_PLUS4;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (idle_expire) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_EXEC;
        end else if (fetch_expire) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXEC: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (!stall) begin
          state_d = ST_FETCH;
        end
      end
      default:  state_d = state_q;
    endcase
    imem_req_d      = (state_d == ST_FETCH);
    instr_valid_d   = (state_q == ST_FETCH) && (state_d == ST_EXEC);
    fetch_timeout_d = (state_d == ST_ERROR);
    halted_d        = (state_d == ST_HALTED);
    retired_d       = retired_q + CNT_W'(pc_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      imem_req_q      <= 1'b0;
      instr_valid_q   <= 1'b0;
      fetch_timeout_q <= 1'b0;
      halted_q        <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q         <= state_d;
      imem_req_q      <= imem_req_d;
      instr_valid_q   <= instr_valid_d;
      fetch_timeout_q <= fetch_timeout_d;
      halted_q        <= halted_d;
      retired_q       <= retired_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_timeout = fetch_timeout_q;
  assign halted        = halted_q;
  assign retired       = retired_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - scoreboard bench for the next-PC sequencer
`timescale 1ns/1ps
module tb_pc_seq_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_ack = 1'b0;
  logic             branch = 1'b0, zero = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic             stall = 1'b0, halt = 1'b0;
  logic             imem_req, pc_en, instr_valid, fetch_timeout, halted;
  logic [1:0]       pc_src;
  logic [CNT_W-1:0] retired;

  pc_seq_ctrl #(.RESET_WAIT(1), .FETCH_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .jalr          (jalr),
    .stall         (stall),
    .halt          (halt),
    .pc_src        (pc_src),
    .pc_en         (pc_en),
    .instr_valid   (instr_valid),
    .fetch_timeout (fetch_timeout),
    .halted        (halted),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic       en;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             got, want;
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_retired;

  task automatic clear_ctrl();
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jalr = 1'b0; stall = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    clear_ctrl();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
    sb_q.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Acks the pending fetch, then drives the EXEC-cycle controls and records the expected decode.
  task automatic issue(input bit jr, input bit j, input bit br, input bit z, input bit st,
                       input bit hl, input logic [1:0] esrc, input logic een, output bit ok);
    wait_req(ok);
    if (!ok) return;
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    jalr = jr; jump = j; branch = br; zero = z; stall = st; halt = hl;
    sb_q.push_back('{src: esrc, en: een});
    if (een) exp_retired = exp_retired + 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({imem_req, instr_valid, fetch_timeout, halted, pc_en} !== 5'b0 || pc_src !== 2'd3 || retired !== '0) begin
      n_err++;
      $display("FAIL reset_state: req=%b iv=%b to=%b h=%b en=%b src=%0d ret=%0d, want all 0 with src=3",
               imem_req, instr_valid, fetch_timeout, halted, pc_en, pc_src, retired);
    end
    rst = 1'b0;
    exp_retired = '0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL req_first_cycle: imem_req=%b want 0", imem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL req_second_cycle: imem_req=%b want 1", imem_req);
    end
  endtask

  task automatic test_plus4();
    bit  ok;
    time t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL plus4_wait: no imem_req within budget, instr %0d", k);
        return;
      end
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{src: pc_src, en: pc_en};
      n_cmp++;
      if (got !== want || instr_valid !== 1'b1) begin
        n_err++;
        $display("FAIL plus4_decode: src=%0d en=%b iv=%b, want src=%0d en=%b iv=1",
                 got.src, got.en, instr_valid, want.src, want.en);
      end
      if (k > 0) begin
        n_cmp++;
        if ($time - t_prev != 20) begin
          n_err++;
          $display("FAIL plus4_cadence: %0t ns between EXEC cycles, want 20", $time - t_prev);
        end
      end
      t_prev = $time;
      @(posedge clk);
      #1;
      clear_ctrl();
    end
    n_cmp++;
    if (retired !== 32'd3 || retired !== exp_retired) begin
      n_err++;
      $display("FAIL plus4_retired: retired=%0d want 3", retired);
    end
  endtask

  task automatic test_jumps();
    bit         ok;
    logic [4:0] vec [4];
    logic [1:0] esrc [4];
    vec[0] = 5'b11000; esrc[0] = 2'd2;  // jalr + jump
    vec[1] = 5'b00100; esrc[1] = 2'd0;  // branch, not taken
    vec[2] = 5'b00110; esrc[2] = 2'd1;  // branch taken
    vec[3] = 5'b01000; esrc[3] = 2'd1;  // jump alone
    for (int k = 0; k < 4; k++) begin
      issue(vec[k][4], vec[k][3], vec[k][2], vec[k][1], 0, 0, esrc[k], 1'b1, ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL jumps_wait: no imem_req within budget, case %0d", k);
        return;
      end
      @(negedge clk);
      want = sb_q.pop_front();
      got  = '{src: pc_src, en: pc_en};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL jumps_decode_%0d: src=%0d en=%b, want src=%0d en=%b",
                 k, got.src, got.en, want.src, want.en);
      end
      @(posedge clk);
      #1;
      clear_ctrl();
    end
    n_cmp++;
    if (retired !== exp_retired) begin
      n_err++;
      $display("FAIL jumps_retired: retired=%0d want %0d", retired, exp_retired);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int iv_cnt = 0;
    issue(0, 0, 0, 0, 1, 0, 2'd3, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL stall_wait: no imem_req within budget");
      return;
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c == 3) begin
          stall = 1'b0;
          sb_q.push_back('{src: 2'd0, en: 1'b1});
          exp_retired = exp_retired + 1'b1;
        end else begin
          sb_q.push_back('{src: 2'd3, en: 1'b0});
        end
      end
      @(negedge clk);
      if (instr_valid === 1'b1) iv_cnt++;
      want = sb_q.pop_front();
      got  = '{src: pc_src, en: pc_en};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL stall_cycle_%0d: src=%0d en=%b, want src=%0d en=%b",
                 c, got.src, got.en, want.src, want.en);
      end
      if (c < 3) begin
        n_cmp++;
        if (retired !== exp_retired) begin
          n_err++;
          $display("FAIL stall_retired_%0d: retired=%0d want %0d", c, retired, exp_retired);
        end
      end
    end
    n_cmp++;
    if (iv_cnt != 1) begin
      n_err++;
      $display("FAIL stall_iv_pulses: %0d pulses want 1", iv_cnt);
    end
    @(posedge clk);
    #1;
    clear_ctrl();
    n_cmp++;
    if (retired !== exp_retired) begin
      n_err++;
      $display("FAIL stall_release_retired: retired=%0d want %0d", retired, exp_retired);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    wait_req(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL timeout_wait: no imem_req within budget");
      return;
    end
    repeat (7) @(negedge clk);
    n_cmp++;
    if (fetch_timeout !== 1'b0 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_cycle8: to=%b req=%b, want to=0 req=1", fetch_timeout, imem_req);
    end
    @(negedge clk);
    n_cmp++;
    if (fetch_timeout !== 1'b1 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flag: to=%b req=%b, want to=1 req=0", fetch_timeout, imem_req);
    end
    imem_ack = 1'b1;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (fetch_timeout !== 1'b1 || pc_en !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_sticky: to=%b en=%b iv=%b, want 1/0/0", fetch_timeout, pc_en, instr_valid);
    end

    do_reset();
    wait_req(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL late_ack_wait: no imem_req within budget");
      return;
    end
    repeat (7) @(negedge clk);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    sb_q.push_back('{src: 2'd0, en: 1'b1});
    @(negedge clk);
    want = sb_q.pop_front();
    got  = '{src: pc_src, en: pc_en};
    n_cmp++;
    if (got !== want || instr_valid !== 1'b1 || fetch_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL late_ack: src=%0d en=%b iv=%b to=%b, want src=%0d en=%b iv=1 to=0",
               got.src, got.en, instr_valid, fetch_timeout, want.src, want.en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_halt();
    bit ok;
    int bad = 0;
    do_reset();
    issue(0, 0, 0, 0, 1, 1, 2'd3, 1'b0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL halt_wait: no imem_req within budget");
      return;
    end
    @(negedge clk);
    want = sb_q.pop_front();
    got  = '{src: pc_src, en: pc_en};
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL halt_decode: src=%0d en=%b, want src=%0d en=%b", got.src, got.en, want.src, want.en);
    end
    @(posedge clk);
    #1;
    clear_ctrl();
    jump = 1'b1;
    for (int c = 0; c < 10; c++) begin
      imem_ack = c[0];
      @(negedge clk);
      if (halted !== 1'b1 || pc_en !== 1'b0 || imem_req !== 1'b0 || pc_src !== 2'd3) bad++;
    end
    imem_ack = 1'b0;
    clear_ctrl();
    n_cmp++;
    if (bad != 0 || retired !== exp_retired) begin
      n_err++;
      $display("FAIL halt_terminal: %0d bad cycles, retired=%0d want %0d", bad, retired, exp_retired);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    issue(0, 0, 0, 0, 0, 0, 2'd0, 1'b1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL arst_wait: no imem_req within budget");
      return;
    end
    @(negedge clk);
    void'(sb_q.pop_front());
    @(posedge clk);
    #1;
    clear_ctrl();
    wait_req(ok);
    n_cmp++;
    if (!ok || retired !== 32'd1) begin
      n_err++;
      $display("FAIL arst_pre: req_seen=%b retired=%0d, want 1/1", ok, retired);
    end
    #2;
    imem_ack = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || retired !== '0 || pc_src !== 2'd3 || pc_en !== 1'b0) begin
      n_err++;
      $display("FAIL arst_immediate: req=%b ret=%0d src=%0d en=%b, want 0/0/3/0",
               imem_req, retired, pc_src, pc_en);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL arst_ack_ignored: iv=%b req=%b, want 0/0", instr_valid, imem_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_plus4();
    test_jumps();
    test_stall();
    test_timeout();
    test_halt();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Sequencing controller for the single-cycle core's next-PC path.
- Runs a fetch/execute handshake with instruction memory and drives the `pc_src` select and PC-register load enable that feed `pc_mux`.
- Handles stall, halt and instruction-fetch timeout, and keeps a retired-instruction counter.
- Sits between the control unit / branch logic and the PC register.

Parameters:
- RESET_WAIT, 1, cycles spent in IDLE after reset release before the first fetch (≥1).
- FETCH_TIMEOUT, 8, max cycles in FETCH without imem_ack before ERROR (≥2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request to instruction memory (registered).
- imem_ack  in  1  instruction memory data valid.
- branch  in  1  current instruction is a conditional branch.
- zero  in  1  branch condition true (from ALU).
- jump  in  1  JAL.
- jalr  in  1  JALR.
- stall  in  1  hold current instruction (external hazard).
- halt  in  1  ECALL/EBREAK-style stop request.
- pc_src  out  2  select to pc_mux: 0 = plus4, 1 = target, 2 = alu, 3 = prev.
- pc_en  out  1  PC register load enable.
- instr_valid  out  1  one-cycle pulse, instruction latched.
- fetch_timeout  out  1  sticky fetch error flag.
- halted  out  1  controller in HALTED.
- retired  out  CNT_W  count of cycles with pc_en = 1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - imem_req = 0, instr_valid = 0, fetch_timeout = 0, halted = 0, retired = 0.
  - pc_src = 3, pc_en = 0.
- States: IDLE, FETCH, EXEC, HALTED, ERROR.
- IDLE:
  - Wait RESET_WAIT cycles, then go to FETCH.
  - imem_req rises on the FETCH entry edge. With the default, imem_req is 1 in the 2nd cycle after reset release.
- FETCH:
  - imem_req = 1.
  - Wait counter starts at 0 on entry and increments every cycle without imem_ack.
  - imem_ack = 1: go to EXEC, imem_req drops, and instr_valid = 1 for exactly the first EXEC cycle.
  - Counter reaches FETCH_TIMEOUT−1 with imem_ack = 0: go to ERROR.
  - If imem_ack and timeout coincide in the same cycle, imem_ack wins.
- EXEC (pc_src and pc_en are a combinational decode of state and inputs). Priority, highest first:
  1. halt: pc_src = 3, pc_en = 0, go to HALTED.
  2. stall: pc_src = 3, pc_en = 0, stay in EXEC (instr_valid not re-pulsed).
  3. jalr: pc_src = 2, pc_en = 1, go to FETCH.
  4. jump, or branch & zero: pc_src = 1, pc_en = 1, go to FETCH.
  5. Otherwise: pc_src = 0, pc_en = 1, go to FETCH.
  - branch & !zero falls through to case 5 (plus4).
- Any state other than EXEC: pc_src = 3, pc_en = 0.
- HALTED: halted = 1; terminal until reset.
- ERROR: fetch_timeout = 1 (sticky); terminal until reset.
- retired: increments by 1 on each edge where pc_en = 1; wraps modulo 2^CNT_W with no flag.
- Steady-state cost without stalls: 2 cycles per instruction when imem_ack arrives the cycle after the request (FETCH 1 + EXEC 1).
- Reset asserted mid-operation (any state): all registers return to reset values immediately, regardless of clk. An in-flight imem_ack is ignored.

Decomposition:
- Shared package `core_pkg`:
  - pc_src encodings: PC_SRC_PLUS4 = 2'd0, PC_SRC_TARGET = 2'd1, PC_SRC_ALU = 2'd2, PC_SRC_PREV = 2'd3. The same constants are used by pc_mux.
  - State enum.
- One sub-module, `fetch_timer`: loadable down-counter with clear-on-entry and an expire output, instantiated for both the IDLE wait and the FETCH timeout.

Test Plan:
1. Reset, release, imem_ack = 1 one cycle after imem_req, no control inputs → pc_src = 0 with pc_en = 1 once per 2 cycles; retired = 3 after 3 instructions.
2. In EXEC, drive jalr = 1 and jump = 1 together → pc_src = 2 (jalr wins). Next instruction, branch = 1 and zero = 0 → pc_src = 0. Then branch = 1 and zero = 1 → pc_src = 1.
3. stall = 1 for 3 cycles in EXEC → pc_src = 3 and pc_en = 0 for 3 cycles, instr_valid pulses once, retired unchanged; on stall release → pc_src = 0, pc_en = 1.
4. Hold imem_ack = 0 in FETCH → fetch_timeout = 1 after 8 cycles and stays 1; the same stimulus with imem_ack in cycle 8 → EXEC, no error.
5. halt = 1 together with stall = 1 in EXEC → HALTED, halted = 1, pc_en stays 0 forever, imem_req = 0.
6. Assert rst mid-FETCH with imem_req = 1 → imem_req = 0, retired = 0, pc_src = 3 before the next clk edge.
